// File: rtl/pb_noc_link_pipe_pkg.sv
// Shared constants and helper types for the inter-tile NoC link pipelines.
// Every tile link instance picks up its default depth and counter width here.
package pb_noc_link_pipe_pkg;

   localparam int LinkPipeStages   = 2;
   localparam int LinkPipeCntWidth = 32;

   // Per-stage fill level: 0, 1 or 2 flits.
   typedef logic [1:0] stage_occ_t;

   // Width of the occupancy count; kept at least 1 bit so a zero-stage link still has a port.
   function automatic int occ_width(input int stages);
      return (stages > 0) ? $clog2(2 * stages + 1) : 1;
   endfunction

endpackage

// File: rtl/pb_noc_link_pipe_if.sv
// One valid/ready/payload channel of a FlooNoC link.
// The master drives valid and data; the slave drives ready.
interface pb_noc_link_pipe_if #(
   parameter type flit_t = logic
);
   logic  valid;
   logic  ready;
   flit_t data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pb_noc_link_pipe_spill_stage.sv
// Two-entry spill register (A = output slot, B = spill slot).
// ready_o depends only on the B valid flop, so ready_i never reaches it combinationally.
module pb_spill_stage
   import pb_noc_link_pipe_pkg::*;
#(
   parameter type flit_t = logic
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       valid_i,
   output logic       ready_o,
   input  flit_t      data_i,
   output logic       valid_o,
   input  logic       ready_i,
   output flit_t      data_o,
   output stage_occ_t occ_o
);

   logic  a_vld, b_vld;
   flit_t a_dat, b_dat;
   logic  in_hs, out_hs, a_load_in, a_from_b;

   assign ready_o = !b_vld;
   assign valid_o = a_vld;
   assign data_o  = a_dat;
   assign occ_o   = {1'b0, a_vld} + {1'b0, b_vld};

   assign in_hs  = valid_i && !b_vld;
   assign out_hs = a_vld && ready_i;
   // A new flit takes A whenever A is free at the edge; B only absorbs a flit behind a stalled A.
   assign a_load_in = in_hs && (!a_vld || (out_hs && !b_vld));
   assign a_from_b  = out_hs && b_vld;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_vld <= 1'b0;
         b_vld <= 1'b0;
         a_dat <= '0;
         b_dat <= '0;
      end else begin
         if (a_from_b) begin
            a_dat <= b_dat;
         end else if (a_load_in) begin
            a_dat <= data_i;
         end
         a_vld <= a_from_b || a_load_in || (a_vld && !out_hs);
         if (in_hs && !a_load_in) begin
            b_vld <= 1'b1;
            b_dat <= data_i;
         end else if (a_from_b) begin
            b_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pb_noc_link_pipe.sv
// Elastic full-throughput link pipeline: NumStages chained spill registers plus
// saturating flit/stall counters for link profiling. NumStages=0 is a plain wire.
module pb_noc_link_pipe
   import pb_noc_link_pipe_pkg::*;
#(
   parameter type flit_t    = logic,
   parameter int  NumStages = LinkPipeStages,
   parameter int  CntWidth  = LinkPipeCntWidth
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                clr_cnt_i,
   pb_noc_link_pipe_if.slave                   in_ch,
   pb_noc_link_pipe_if.master                  out_ch,
   output logic [occ_width(NumStages)-1:0]     occupancy_o,
   output logic [CntWidth-1:0]                 flit_cnt_o,
   output logic [CntWidth-1:0]                 stall_cnt_o
);

   localparam int OccW = occ_width(NumStages);

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] cnt,
                                                   input logic              inc);
      if (inc && (cnt != '1)) return cnt + CntWidth'(1);
      return cnt;
   endfunction

   logic out_hs, out_stall;

   generate
      if (NumStages == 0) begin : g_bypass
         assign out_ch.valid = in_ch.valid;
         assign out_ch.data  = in_ch.data;
         assign in_ch.ready  = out_ch.ready;
         assign occupancy_o  = '0;
      end else begin : g_pipe
         logic [NumStages:0] stg_vld;
         logic [NumStages:0] stg_rdy;
         flit_t              stg_dat [NumStages+1];
         stage_occ_t         stg_occ [NumStages];

         assign stg_vld[0]          = in_ch.valid;
         assign stg_dat[0]          = in_ch.data;
         assign in_ch.ready         = stg_rdy[0];
         assign out_ch.valid        = stg_vld[NumStages];
         assign out_ch.data         = stg_dat[NumStages];
         assign stg_rdy[NumStages]  = out_ch.ready;

         for (genvar i = 0; i < NumStages; i++) begin : g_stage
            pb_spill_stage #(.flit_t(flit_t)) u_stage (
               .clk_i   (clk_i),
               .rst_ni  (rst_ni),
               .valid_i (stg_vld[i]),
               .ready_o (stg_rdy[i]),
               .data_i  (stg_dat[i]),
               .valid_o (stg_vld[i+1]),
               .ready_i (stg_rdy[i+1]),
               .data_o  (stg_dat[i+1]),
               .occ_o   (stg_occ[i])
            );
         end

         always_comb begin
            occupancy_o = '0;
            for (int i = 0; i < NumStages; i++) begin
               occupancy_o = occupancy_o + OccW'(stg_occ[i]);
            end
         end
      end
   endgenerate

   assign out_hs    = out_ch.valid && out_ch.ready;
   assign out_stall = out_ch.valid && !out_ch.ready;

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flit_cnt_o  <= '0;
         stall_cnt_o <= '0;
      end else if (clr_cnt_i) begin
         flit_cnt_o  <= '0;
         stall_cnt_o <= '0;
      end else begin
         flit_cnt_o  <= sat_inc(flit_cnt_o, out_hs);
         stall_cnt_o <= sat_inc(stall_cnt_o, out_stall);
      end
   end

   a_upstream_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      in_ch.valid && !in_ch.ready |=> in_ch.valid && $stable(in_ch.data))
      else $error("upstream valid_i retracted or data_i changed while stalled");

   a_downstream_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_ch.valid && !out_ch.ready |=> out_ch.valid && $stable(out_ch.data))
      else $error("valid_o dropped or data_o changed while stalled");

endmodule

// File: tb/tb_pb_noc_link_pipe.sv
// Directed + random bench for pb_noc_link_pipe: a FIFO/counter model checked every
// cycle, plus literal expectations for latency, fill, drain, saturation and reset.
module tb_pb_noc_link_pipe;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       clr;
   logic       drv_valid;
   logic [7:0] drv_data;
   logic       drv_ready;

   logic [2:0]  occ_a, occ_b;
   logic [31:0] fcnt_a, scnt_a;
   logic [3:0]  fcnt_b, scnt_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pb_noc_link_pipe_if #(.flit_t(logic [7:0])) in_a ();
   pb_noc_link_pipe_if #(.flit_t(logic [7:0])) out_a ();
   pb_noc_link_pipe_if #(.flit_t(logic [7:0])) in_b ();
   pb_noc_link_pipe_if #(.flit_t(logic [7:0])) out_b ();

   assign in_a.valid  = drv_valid;
   assign in_a.data   = drv_data;
   assign out_a.ready = drv_ready;
   assign in_b.valid  = drv_valid;
   assign in_b.data   = drv_data;
   assign out_b.ready = drv_ready;

   pb_noc_link_pipe #(.flit_t(logic [7:0]), .NumStages(2), .CntWidth(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clr_cnt_i(clr),
      .in_ch(in_a), .out_ch(out_a),
      .occupancy_o(occ_a), .flit_cnt_o(fcnt_a), .stall_cnt_o(scnt_a));

   pb_noc_link_pipe #(.flit_t(logic [7:0]), .NumStages(2), .CntWidth(4)) dut_s (
      .clk_i(clk), .rst_ni(rst_ni), .clr_cnt_i(clr),
      .in_ch(in_b), .out_ch(out_b),
      .occupancy_o(occ_b), .flit_cnt_o(fcnt_b), .stall_cnt_o(scnt_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a FIFO of accepted flits plus plain counters.
   logic [7:0]  q[$];
   logic [31:0] m_f, m_s;
   logic [3:0]  m_fb, m_sb;
   logic        prev_vld, prev_rdy;
   logic [7:0]  prev_dat;

   always @(negedge clk) begin
      if (!rst_ni) begin
         chk("rst_valid_o", out_a.valid, 0);
         chk("rst_ready_o", in_a.ready, 1);
         chk("rst_occ", occ_a, 0);
         chk("rst_cnt", fcnt_a, 0);
         chk("rst_valid_o_s", out_b.valid, 0);
         q.delete();
         m_f = 0; m_s = 0; m_fb = 0; m_sb = 0;
         prev_vld = 0; prev_rdy = 0; prev_dat = 0;
      end else begin
         chk("occ", occ_a, q.size());
         chk("occ_s", occ_b, q.size());
         chk("flit_cnt", fcnt_a, m_f);
         chk("stall_cnt", scnt_a, m_s);
         chk("flit_cnt_s", fcnt_b, m_fb);
         chk("stall_cnt_s", scnt_b, m_sb);
         if (q.size() == 0) begin
            chk("valid_empty", out_a.valid, 0);
            chk("valid_empty_s", out_b.valid, 0);
         end
         if (out_a.valid && q.size() > 0) chk("data_order", out_a.data, q[0]);
         if (out_b.valid && q.size() > 0) chk("data_order_s", out_b.data, q[0]);
         if (q.size() != 3) begin
            chk("ready_rule", in_a.ready, (q.size() < 3) ? 1 : 0);
            chk("ready_rule_s", in_b.ready, (q.size() < 3) ? 1 : 0);
         end
         if (prev_vld && !prev_rdy) begin
            chk("hold_valid", out_a.valid, 1);
            chk("hold_data", out_a.data, prev_dat);
         end
         if (out_a.valid && drv_ready && q.size() > 0) void'(q.pop_front());
         if (drv_valid && in_a.ready) q.push_back(drv_data);
         if (clr) begin
            m_f = 0; m_s = 0; m_fb = 0; m_sb = 0;
         end else if (out_a.valid) begin
            if (drv_ready) begin
               if (m_f != 32'hFFFF_FFFF) m_f = m_f + 1;
               if (m_fb != 4'hF) m_fb = m_fb + 1;
            end else begin
               if (m_s != 32'hFFFF_FFFF) m_s = m_s + 1;
               if (m_sb != 4'hF) m_sb = m_sb + 1;
            end
         end
         prev_vld = out_a.valid;
         prev_rdy = drv_ready;
         prev_dat = out_a.data;
      end
   end

   logic       obs_v [18];
   logic [7:0] obs_d [18];
   logic [7:0] got   [5];
   logic [7:0] exp_drain [5];

   initial begin
      int acc, nout, sent, seen;
      logic [31:0] s0;
      bit aa_done, accepted;

      rst_ni = 0; clr = 0; drv_valid = 0; drv_data = 0; drv_ready = 0;
      repeat (2) tick();
      rst_ni = 1;
      @(negedge clk);
      chk("init_valid_o", out_a.valid, 0);
      chk("init_ready_o", in_a.ready, 1);
      chk("init_occ", occ_a, 0);
      tick();

      // Streaming 0x01..0x10 with ready_i held high.
      drv_ready = 1;
      for (int k = 0; k < 18; k++) begin
         drv_valid = (k < 16);
         drv_data  = 8'(k + 1);
         @(negedge clk);
         obs_v[k] = out_a.valid;
         obs_d[k] = out_a.data;
         tick();
      end
      drv_valid = 0;
      chk("lat_cycle0", obs_v[0], 0);
      chk("lat_cycle1", obs_v[1], 0);
      for (int k = 2; k < 18; k++) begin
         chk("stream_valid", obs_v[k], 1);
         chk("stream_data", obs_d[k], 32'(k - 1));
      end
      @(negedge clk);
      chk("stream_flit_cnt", fcnt_a, 16);
      chk("stream_stall_cnt", scnt_a, 0);
      chk("stream_flit_cnt_sat", fcnt_b, 15);
      tick();

      // Fill with ready_i low; the flit after the fourth is 0xAA and stays offered.
      drv_ready = 0;
      acc = 0;
      for (int k = 0; k < 10; k++) begin
         drv_valid = 1;
         drv_data  = (acc < 4) ? 8'(8'h21 + acc) : 8'hAA;
         @(negedge clk);
         if (!in_a.ready) break;
         acc++;
         tick();
      end
      chk("fill_accepted", acc, 4);
      chk("fill_occ", occ_a, 4);
      chk("fill_head_valid", out_a.valid, 1);
      chk("fill_head_data", out_a.data, 8'h21);
      s0 = scnt_a;
      tick();
      @(negedge clk);
      chk("stall_step1", scnt_a, s0 + 1);
      tick();
      @(negedge clk);
      chk("stall_step2", scnt_a, s0 + 2);
      tick();

      // Drain while 0xAA is still being pushed.
      drv_ready = 1;
      nout = 0;
      aa_done = 0;
      for (int c = 0; c < 20 && nout < 5; c++) begin
         @(negedge clk);
         if (out_a.valid) begin
            got[nout] = out_a.data;
            nout++;
         end
         if (drv_valid && in_a.ready) aa_done = 1;
         tick();
         if (aa_done) drv_valid = 0;
      end
      exp_drain[0] = 8'h21; exp_drain[1] = 8'h22; exp_drain[2] = 8'h23;
      exp_drain[3] = 8'h24; exp_drain[4] = 8'hAA;
      chk("drain_count", nout, 5);
      for (int i = 0; i < 5; i++) chk("drain_order", got[i], exp_drain[i]);

      // Clear during a handshake, then 20 more handshakes saturate the 4-bit counter.
      for (int k = 0; k < 30; k++) begin
         drv_valid = (k < 25);
         drv_data  = 8'(8'h40 + k);
         clr       = (k == 6);
         @(negedge clk);
         if (k == 6) chk("clr_same_cycle_hs", out_a.valid, 1);
         if (k == 7) begin
            chk("clr_priority", fcnt_a, 0);
            chk("clr_priority_s", fcnt_b, 0);
         end
         tick();
      end
      clr = 0;
      drv_valid = 0;
      @(negedge clk);
      chk("post_clr_cnt", fcnt_a, 20);
      chk("saturate_4bit", fcnt_b, 15);
      tick();

      // Random valid/ready traffic; valid_i is never retracted before acceptance.
      sent = 0;
      for (int c = 0; c < 40000 && sent < 10000; c++) begin
         if (!drv_valid) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_data  = 8'($urandom);
         end
         drv_ready = ($urandom_range(0, 3) != 0);
         accepted = 0;
         @(negedge clk);
         if (drv_valid && in_a.ready) begin
            sent++;
            accepted = 1;
         end
         tick();
         if (accepted) drv_valid = 0;
      end
      chk("random_sent", sent, 10000);
      drv_valid = 0;
      drv_ready = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (occ_a == 0) break;
         tick();
      end
      chk("random_drained", occ_a, 0);
      tick();

      // Reset with three flits held.
      drv_ready = 0;
      for (int k = 0; k < 3; k++) begin
         drv_valid = 1;
         drv_data  = 8'(8'h51 + k);
         @(negedge clk);
         tick();
      end
      drv_valid = 0;
      @(negedge clk);
      chk("pre_reset_occ", occ_a, 3);
      tick();
      rst_ni = 0;
      #1;
      chk("async_rst_valid", out_a.valid, 0);
      chk("async_rst_occ", occ_a, 0);
      chk("async_rst_ready", in_a.ready, 1);
      tick();
      rst_ni = 1;
      drv_ready = 1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_a.valid || out_b.valid) seen++;
         tick();
      end
      chk("no_stale_flit", seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

endmodule
